btn_conditioner: RTL
====================

# btn_conditioner

Input-side conditioner for the board push-buttons. Each raw, asynchronous, bouncing `i_btn` line is synchronised, debounced and converted into a stable level plus one-cycle press and release pulses. The block sits between the board pins and the LED control top level. Control logic therefore sees exactly one `o_btn_press` pulse per physical press, instead of a level that toggles mode every clock.

## Interface
- `NB_BTN`, default 4: number of buttons handled; all per-button logic is replicated.
- `NB_COUNTER`, default 20: width of each debounce counter.
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept a change (10 ms at 100 MHz). Legal range is 2..2^NB_COUNTER-1.

Ports:
- `clock`, input, 1 bit: system clock, rising-edge.
- `i_reset`, input, 1 bit: synchronous, active-high reset.
- `i_btn`, input, NB_BTN bits: raw button pins, asynchronous, active-high.
- `o_btn_level`, output, NB_BTN bits: debounced button state.
- `o_btn_press`, output, NB_BTN bits: one-cycle pulse on an accepted 0→1 change.
- `o_btn_release`, output, NB_BTN bits: one-cycle pulse on an accepted 1→0 change.
- `o_any_press`, output, 1 bit: OR of `o_btn_press`.

## Operation
- Synchroniser: two flip-flop stages per bit, `sync1` then `sync2`. Only `sync2` feeds the debouncer.
- Per-button FSM with states IDLE_LOW, CHECK_HIGH, IDLE_HIGH, CHECK_LOW:
  - IDLE_LOW: level 0, counter 0. If `sync2`=1, go to CHECK_HIGH with counter=1.
  - CHECK_HIGH: if `sync2`=0, return to IDLE_LOW and clear the counter (glitch rejected).
    - Otherwise increment the counter.
    - When the counter reaches DEBOUNCE_CYCLES, go to IDLE_HIGH. In that same edge, set level=1 and assert the press pulse.
  - IDLE_HIGH and CHECK_LOW mirror the two states above with polarity inverted. Acceptance clears level and asserts the release pulse.
- Counter arithmetic: unsigned, NB_COUNTER bits. The counter never exceeds DEBOUNCE_CYCLES, so it never wraps. It is cleared on every state entry to IDLE_*.
- Pulses are registered outputs and drop automatically on the following edge. Press and release can never be asserted together on one bit.
- Buttons are fully independent. Simultaneous presses on several bits produce simultaneous pulses; no priority is applied here.
- Reset (any cycle, including mid-CHECK):
  - All states go to IDLE_LOW.
  - Counters, sync registers, `o_btn_level`, `o_btn_press`, `o_btn_release` and `o_any_press` go to 0.
  - A button held through reset is re-qualified after deassertion as a fresh press: it needs the full debounce and then produces one press pulse.

## Timing
- Latency: a clean step on `i_btn[n]` sampled at edge 0 sets `sync2` at edge 1. CHECK is entered at edge 2. Level and pulse become valid after edge DEBOUNCE_CYCLES+1. Total is DEBOUNCE_CYCLES+2 edges from pin to output, identical for press and release.
- Minimum accepted press width is DEBOUNCE_CYCLES cycles of stable `sync2`. Any bounce shorter than that restarts qualification.
- Pulse width is exactly 1 cycle. There is a minimum of 2·DEBOUNCE_CYCLES cycles between two press pulses on the same bit.
- `o_any_press` is registered with the pulses and has no additional latency.
- All outputs change only on the rising `clock` edge; there are no combinational paths from `i_btn`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset: hold `i_reset` for 3 cycles with `i_btn`=4'b1111. All outputs are 0 during reset. After release, `o_btn_level`=4'b1111 and `o_btn_press`=4'b1111 for exactly one cycle, 6 edges after deassert.
- Clean press: drive `i_btn[0]` 0→1 and hold. `o_btn_press[0]` pulses exactly 6 edges later, `o_btn_level[0]`=1 stays high, and `o_any_press`=1 for that single cycle. Dropping the input gives `o_btn_release[0]` 6 edges after the drop.
- Bounce: toggle `i_btn[1]` 1,0,1,1,0,1 on successive cycles, then hold 1. There is no pulse during the bounce. Exactly one `o_btn_press[1]` pulse occurs 6 edges after the final rising sample.
- Short glitch: pulse `i_btn[2]` high for 3 cycles only. `o_btn_level[2]` stays 0 and no press or release pulse occurs.
- Simultaneous press: `i_btn` 0000→0110 on one edge. `o_btn_press`=4'b0110 in one cycle and `o_any_press`=1 in that cycle only.
- Reset mid-qualification: assert `i_reset` 2 cycles into CHECK_HIGH on bit 3. Counter and outputs clear. After deassertion with the button still held, one press pulse occurs 6 edges later and no earlier.

Source files
------------

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronises, debounces and edge-detects raw push-button pins,
// producing a stable level plus one-cycle press/release pulses per button.
module btn_conditioner #(
   parameter int NB_BTN          = 4,
   parameter int NB_COUNTER      = 20,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic              clock,
   input  logic              i_reset,
   input  logic [NB_BTN-1:0] i_btn,
   output logic [NB_BTN-1:0] o_btn_level,
   output logic [NB_BTN-1:0] o_btn_press,
   output logic [NB_BTN-1:0] o_btn_release,
   output logic              o_any_press
);
   typedef enum logic [1:0] {IDLE_LOW, CHECK_HIGH, IDLE_HIGH, CHECK_LOW} state_t;
   // Acceptance happens on the edge where the counter would reach DEBOUNCE_CYCLES.
   localparam logic [NB_COUNTER-1:0] LAST = NB_COUNTER'(DEBOUNCE_CYCLES - 1);
   localparam logic [NB_COUNTER-1:0] ONE  = NB_COUNTER'(1);
   logic [NB_BTN-1:0] sync1, sync2, press_next, release_next;
   always_ff @(posedge clock) begin
      if (i_reset) begin
         sync1         <= '0;
         sync2         <= '0;
         o_btn_press   <= '0;
         o_btn_release <= '0;
         o_any_press   <= 1'b0;
      end else begin
         sync1         <= i_btn;
         sync2         <= sync1;
         o_btn_press   <= press_next;
         o_btn_release <= release_next;
         o_any_press   <= |press_next;
      end
   end
   for (genvar n = 0; n < NB_BTN; n++) begin : g_btn
      state_t                state, state_next;
      logic [NB_COUNTER-1:0] count, count_next;
      logic                  press_bit, release_bit;
      always_ff @(posedge clock) begin
         if (i_reset) begin
            state <= IDLE_LOW;
            count <= '0;
         end else begin
            state <= state_next;
            count <= count_next;
         end
      end
      always_comb begin
         state_next  = state;
         count_next  = count + ONE;
         press_bit   = 1'b0;
         release_bit = 1'b0;
         case (state)
            IDLE_LOW: begin
               state_next = sync2[n] ? CHECK_HIGH : IDLE_LOW;
               count_next = sync2[n] ? ONE : '0;
            end
            CHECK_HIGH: begin
               if (!sync2[n]) begin
                  state_next = IDLE_LOW;
                  count_next = '0;
               end else if (count == LAST) begin
                  state_next = IDLE_HIGH;
                  count_next = '0;
                  press_bit  = 1'b1;
               end
            end
            IDLE_HIGH: begin
               state_next = sync2[n] ? IDLE_HIGH : CHECK_LOW;
               count_next = sync2[n] ? '0 : ONE;
            end
            CHECK_LOW: begin
               if (sync2[n]) begin
                  state_next = IDLE_HIGH;
                  count_next = '0;
               end else if (count == LAST) begin
                  state_next  = IDLE_LOW;
                  count_next  = '0;
                  release_bit = 1'b1;
               end
            end
            default: begin
               state_next = IDLE_LOW;
               count_next = '0;
            end
         endcase
      end
      assign press_next[n]   = press_bit;
      assign release_next[n] = release_bit;
      assign o_btn_level[n]  = (state == IDLE_HIGH) || (state == CHECK_LOW);
   end
endmodule
